// File: rtl/sft_pkg.sv
// rtl/sft_pkg.sv - shared definitions for the serial frame transmitter
// Purpose: field widths, line levels and FSM state encoding shared by the
//          transmitter top, its bit timer and its bus interface.
// Ports:   none (package)
package sft_pkg;

  localparam int ADDR_W  = 2;
  localparam int CNT_W   = 4;
  localparam int DATA_W  = 16;

  // Index widths used to select one bit of the port/count fields
  localparam int ADDR_IW = $clog2(ADDR_W);
  localparam int CNT_IW  = $clog2(CNT_W);

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    CNT,
    DATA
  } state_e;

endpackage

// File: rtl/sft_if.sv
// rtl/sft_if.sv - request/line bundle between frame source and transmitter
// Purpose: groups the clock enable, frame request fields and transmitter outputs.
// Ports:   master drives clkEn/start/port_sel/count/data and observes SerOut/busy/done;
//          slave (the transmitter) is the mirror image.
interface sft_if;
  import sft_pkg::*;

  logic              clkEn;
  logic              start;
  logic [ADDR_W-1:0] port_sel;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] data;
  logic              SerOut;
  logic              busy;
  logic              done;

  modport master (
    output clkEn, start, port_sel, count, data,
    input  SerOut, busy, done
  );

  modport slave (
    input  clkEn, start, port_sel, count, data,
    output SerOut, busy, done
  );

endinterface

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit period tick counter
// Purpose: counts enabled clock edges 0..BIT_TICKS-1 and flags the last one.
// Ports:   clk, rst (sync, active high); clr restarts the period;
//          en advances the count; bit_end is high on the edge that ends a period.
module bit_timer #(
  parameter int BIT_TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST = TICK_W'(BIT_TICKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;

  assign bit_end = en && (tick_q == LAST);

  always_comb begin
    tick_d = tick_q;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter (start | port | count | payload)
// Purpose: latches a frame request and shifts it out MSB first, one bit per
//          BIT_TICKS enabled clocks; line idles high.
// Ports:   clk, rst (sync, active high); bus (sft_if.slave): clkEn, start,
//          port_sel, count, data in; SerOut, busy, done out (all registered).
module serial_frame_tx
  import sft_pkg::*;
#(
  parameter int BIT_TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  sft_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              timer_en;
  logic              bit_end;
  logic              last_idx;
  logic [CNT_W-1:0]  idx_m1;

  assign accept   = (state_q == IDLE) && bus.clkEn && bus.start;
  assign timer_en = bus.clkEn && (state_q != IDLE);
  assign last_idx = (idx_q == '0);
  assign idx_m1   = idx_q - 1'b1;

  bit_timer #(.BIT_TICKS(BIT_TICKS)) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (timer_en),
    .bit_end (bit_end)
  );

  // The next line bit is loaded at the edge that ends the current bit, so
  // SerOut always comes straight from a flop.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          port_d  = bus.port_sel;
          cnt_d   = bus.count;
          data_d  = bus.data;
          state_d = START;
          ser_d   = START_LEVEL;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = PORT;
          idx_d   = CNT_W'(ADDR_W - 1);
          ser_d   = port_q[ADDR_W-1];
        end
      end
      PORT: begin
        if (bit_end) begin
          if (last_idx) begin
            state_d = CNT;
            idx_d   = CNT_W'(CNT_W - 1);
            ser_d   = cnt_q[CNT_W-1];
          end else begin
            idx_d = idx_m1;
            ser_d = port_q[idx_m1[ADDR_IW-1:0]];
          end
        end
      end
      CNT: begin
        if (bit_end) begin
          if (last_idx) begin
            state_d = DATA;
            idx_d   = cnt_q;
            ser_d   = data_q[cnt_q];
          end else begin
            idx_d = idx_m1;
            ser_d = cnt_q[idx_m1[CNT_IW-1:0]];
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_idx) begin
            state_d = IDLE;
            ser_d   = IDLE_LEVEL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_m1;
            ser_d = data_q[idx_m1];
          end
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      ser_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SerOut = ser_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
